pdm_port_rx: RTL and testbench

Per-port receive buffer that sits directly downstream of one `pdm_core` output port (`newdata_len_N` / `proceed_N` / `data_out_N`). It grants a pending packet only when the whole packet fits in its local FIFO, captures the bytes, and re-presents them to a local consumer as a valid/ready byte stream with a last-byte marker. The design uses one instance per output port (four in total).

---
 rtl/pdm_port_rx.sv | 142 ++++++++++++++
 tb/tb_pdm_port_rx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_port_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pdm_port_rx : grant-when-it-fits receive buffer for one pdm_core port    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module pdm_port_rx #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [LEN_W-1:0]  newdata_len,
    output logic              proceed,
    input  logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              drop_pulse
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_PW = C_AW + 1;
    localparam int C_CW = (LEN_W > C_PW) ? LEN_W : C_PW;
    localparam logic [C_CW-1:0] C_DEPTH = C_CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RECV  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [LEN_W-1:0]   r_len_q;
    logic [LEN_W-1:0]   r_rem;
    logic               r_drop_q;
    logic [DATA_W:0]    r_mem [DEPTH];
    logic [C_PW-1:0]    r_wr_ptr;
    logic [C_PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]   r_pkt_count;
    logic               r_drop_pulse;

    logic [C_PW-1:0]    w_occ;
    logic [C_CW-1:0]    w_free;
    logic [C_CW-1:0]    w_len;
    logic [DATA_W:0]    w_head;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_grant;
    logic               w_rem_one;

    // Both operands of the fit check are zero-extended to a common width.
    assign w_occ     = r_wr_ptr - r_rd_ptr;
    assign w_free    = C_DEPTH - C_CW'(w_occ);
    assign w_len     = C_CW'(newdata_len);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                       (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign w_rem_one = (r_rem == LEN_W'(1));
    assign w_pop     = !w_empty && rd_ready;

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_push       = 1'b0;
        proceed      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((w_len != '0) && ((w_len <= w_free) || (w_len > C_DEPTH))) begin
                    w_grant      = 1'b1;
                    w_next_state = S_GRANT;
                end
            end
            S_GRANT: begin
                proceed      = 1'b1;
                w_next_state = r_drop_q ? S_DROP : S_RECV;
            end
            S_RECV: begin
                w_push = 1'b1;
                if (w_rem_one) w_next_state = S_IDLE;
            end
            S_DROP: begin
                if (w_rem_one) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_len_q      <= '0;
            r_drop_q     <= 1'b0;
            r_rem        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pkt_count  <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            if (w_grant) begin
                r_len_q  <= newdata_len;
                r_drop_q <= (w_len > C_DEPTH);
            end
            if (r_state == S_GRANT) begin
                r_rem <= r_len_q;
            end else if ((r_state == S_RECV) || (r_state == S_DROP)) begin
                r_rem <= r_rem - LEN_W'(1);
            end
            if ((r_state == S_RECV) && w_rem_one) r_pkt_count <= r_pkt_count + CNT_W'(1);
            r_drop_pulse <= (r_state == S_DROP) && w_rem_one;
            if (w_push) r_wr_ptr <= r_wr_ptr + C_PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PW'(1);
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[C_AW-1:0]] <= {w_rem_one, data_out};
    end

    assign w_head     = r_mem[r_rd_ptr[C_AW-1:0]];
    assign rd_valid   = !w_empty;
    assign rd_data    = w_empty ? '0 : w_head[DATA_W-1:0];
    assign rd_last    = !w_empty && w_head[DATA_W];
    assign pkt_count  = r_pkt_count;
    assign drop_pulse = r_drop_pulse;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_b) !(w_push && w_full));

endmodule
`default_nettype wire

// File: tb/tb_pdm_port_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pdm_port_rx : vector table, corner sequences and random traffic       |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_pdm_port_rx;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_b;
    logic [LEN_W-1:0]  newdata_len;
    logic              proceed;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_ready;
    logic [CNT_W-1:0]  pkt_count;
    logic              drop_pulse;

    always #5 clk = ~clk;

    pdm_port_rx #(
        .DATA_W(DATA_W),
        .LEN_W (LEN_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .newdata_len(newdata_len),
        .proceed    (proceed),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .rd_ready   (rd_ready),
        .pkt_count  (pkt_count),
        .drop_pulse (drop_pulse)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Core-side driver state
    int              pend_len[$];
    logic [7:0]      pend_bytes[$];
    int              drv_left;
    int              rr_mode;

    // Reference model: the FIFO is a plain queue, the port a byte countdown
    logic [8:0]      mq[$];
    logic            m_proc;
    int              m_left;
    int              m_len;
    logic            m_isdrop;
    logic            m_drop;
    logic [15:0]     m_pkt;

    int n_proc, n_drops, n_pops, last_proc_cyc, last_pop_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_pkt(input int len, input int base);
        pend_len.push_back(len);
        for (int i = 0; i < len; i++) pend_bytes.push_back(8'(base + i));
    endtask

    task automatic model_reset();
        mq.delete();
        m_proc = 1'b0; m_left = 0; m_len = 0; m_isdrop = 1'b0; m_drop = 1'b0; m_pkt = '0;
        drv_left = 0;
        pend_len.delete();
        pend_bytes.delete();
        newdata_len = '0;
        data_out    = '0;
    endtask

    task automatic step();
        int         occ;
        logic       drop_next;
        logic       lastb;
        @(negedge clk);
        if (drv_left > 0) begin
            data_out    = pend_bytes.pop_front();
            drv_left--;
            newdata_len = 8'($urandom);
        end else if (pend_len.size() > 0) begin
            newdata_len = 8'(pend_len[0]);
            data_out    = 8'($urandom);
            if (proceed) drv_left = pend_len.pop_front();
        end else begin
            newdata_len = '0;
            data_out    = 8'($urandom);
        end
        rd_ready = (rr_mode == 2) ? ($urandom_range(0, 9) < 7) : (rr_mode == 1);

        chk("proceed", 32'(proceed), 32'(m_proc));
        chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("rd_data", 32'(rd_data), 32'(mq[0][7:0]));
            chk("rd_last", 32'(rd_last), 32'(mq[0][8]));
        end
        chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
        chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));

        if (proceed) begin n_proc++; last_proc_cyc = cyc; end
        if (drop_pulse) n_drops++;
        if (rd_valid && rd_ready) begin n_pops++; last_pop_cyc = cyc; end

        occ       = mq.size();
        drop_next = 1'b0;
        if (m_proc) begin
            m_proc = 1'b0;
            m_left = m_len;
        end else if (m_left > 0) begin
            lastb = (m_left == 1);
            if (!m_isdrop) mq.push_back({lastb, data_out});
            if (m_left == 1) begin
                if (m_isdrop) drop_next = 1'b1;
                else          m_pkt     = m_pkt + 16'd1;
            end
            m_left--;
        end else if (newdata_len != 0 &&
                     (int'(newdata_len) <= DEPTH - occ || int'(newdata_len) > DEPTH)) begin
            m_proc   = 1'b1;
            m_len    = int'(newdata_len);
            m_isdrop = (int'(newdata_len) > DEPTH);
        end
        if (occ > 0 && rd_ready) void'(mq.pop_front());
        m_drop = drop_next;
        cyc++;
    endtask

    task automatic async_reset();
        #2 rst_b = 1'b0;
        #1;
        chk("rst_proceed", 32'(proceed), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_last", 32'(rd_last), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #3 rst_b = 1'b1;
    endtask

    task automatic drain();
        int i;
        rr_mode = 1;
        i = 0;
        while (i < 300 && (mq.size() > 0 || m_left > 0 || m_proc || pend_len.size() > 0 || drv_left > 0)) begin
            step();
            i++;
        end
        chk("drain_done", 32'(i < 300), 32'd1);
    endtask

    typedef struct {
        int len;
        int exp_proc;
        int exp_pkt;
        int exp_drop;
        int exp_pops;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   p0, k0, d0, q0, p2, got, l;
        int   pc[$];

        vecs[0] = '{4,  1, 1, 0, 4};
        vecs[1] = '{1,  1, 1, 0, 1};
        vecs[2] = '{16, 1, 1, 0, 16};
        vecs[3] = '{17, 1, 0, 1, 0};
        vecs[4] = '{20, 1, 0, 1, 0};
        vecs[5] = '{0,  0, 0, 0, 0};
        vecs[6] = '{2,  1, 1, 0, 2};

        n_proc = 0; n_drops = 0; n_pops = 0; last_proc_cyc = 0; last_pop_cyc = 0;
        rr_mode  = 1;
        rd_ready = 1'b0;
        rst_b    = 1'b0;
        model_reset();
        #1;
        chk("init_proceed", 32'(proceed), 32'd0);
        chk("init_rd_valid", 32'(rd_valid), 32'd0);
        chk("init_pkt_count", 32'(pkt_count), 32'd0);
        chk("init_drop_pulse", 32'(drop_pulse), 32'd0);
        #22 rst_b = 1'b1;

        // Vector table: one packet each from an empty FIFO, consumer always ready
        for (int v = 0; v < 7; v++) begin
            p0 = n_proc; k0 = int'(pkt_count); d0 = n_drops; q0 = n_pops;
            rr_mode = 1;
            add_pkt(vecs[v].len, 8'hA1);
            repeat (vecs[v].len + 10) step();
            pend_len.delete();
            pend_bytes.delete();
            step();
            chk("vec_proceeds", 32'(n_proc - p0), 32'(vecs[v].exp_proc));
            chk("vec_pkt_inc", 32'(int'(pkt_count) - k0), 32'(vecs[v].exp_pkt));
            chk("vec_drops", 32'(n_drops - d0), 32'(vecs[v].exp_drop));
            chk("vec_pops", 32'(n_pops - q0), 32'(vecs[v].exp_pops));
        end

        // Backpressure with a deferred grant
        rr_mode = 0;
        add_pkt(10, 8'h10);
        add_pkt(8, 8'h40);
        repeat (20) step();
        p0 = n_proc;
        repeat (10) step();
        chk("bp_no_grant", 32'(n_proc - p0), 32'd0);
        rr_mode = 1;
        repeat (2) step();
        p2 = last_pop_cyc;
        rr_mode = 0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            step();
            if (n_proc > p0) got = 1;
        end
        chk("bp_grant_delay", 32'(got ? (last_proc_cyc - p2) : 999), 32'd2);
        repeat (12) step();
        chk("bp_full_valid", 32'(rd_valid), 32'd1);
        q0 = n_pops;
        rr_mode = 1;
        repeat (20) step();
        chk("bp_occupancy", 32'(n_pops - q0), 32'd16);
        drain();

        // Exact fill, then a one-byte packet waits for a single pop
        rr_mode = 0;
        k0 = int'(pkt_count);
        add_pkt(16, 8'hC0);
        repeat (20) step();
        chk("fill_pkt", 32'(int'(pkt_count) - k0), 32'd1);
        p0 = n_proc;
        add_pkt(1, 8'hEE);
        repeat (8) step();
        chk("fill_no_grant", 32'(n_proc - p0), 32'd0);
        rr_mode = 1;
        step();
        rr_mode = 0;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            step();
            if (n_proc > p0) got = 1;
        end
        chk("fill_grant_after_pop", 32'(got), 32'd1);
        drain();

        // Reset after the third byte of an eight-byte packet
        rr_mode = 0;
        add_pkt(8, 8'h70);
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            step();
            if (drv_left == 5) got = 1;
        end
        chk("mid_pkt_reached", 32'(got), 32'd1);
        @(posedge clk);
        async_reset();
        rr_mode = 1;
        q0 = n_pops;
        add_pkt(2, 8'h55);
        pend_bytes[1] = 8'hAA;
        repeat (10) step();
        chk("post_rst_pkt_count", 32'(pkt_count), 32'd1);
        chk("post_rst_pops", 32'(n_pops - q0), 32'd2);

        // Back-to-back single-byte packets
        rr_mode = 1;
        k0 = int'(pkt_count);
        add_pkt(1, 8'h11);
        add_pkt(1, 8'h22);
        add_pkt(1, 8'h33);
        for (int i = 0; i < 16; i++) begin
            p0 = n_proc;
            step();
            if (n_proc > p0) pc.push_back(last_proc_cyc);
        end
        chk("b2b_grants", 32'(pc.size()), 32'd3);
        if (pc.size() == 3) begin
            chk("b2b_gap1", 32'(pc[1] - pc[0]), 32'd3);
            chk("b2b_gap2", 32'(pc[2] - pc[1]), 32'd3);
        end
        chk("b2b_pkt", 32'(int'(pkt_count) - k0), 32'd3);

        // Random traffic against the reference model
        rr_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if (pend_len.size() == 0 && drv_left == 0 && $urandom_range(0, 3) == 0) begin
                l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 24)) : int'($urandom_range(1, 16));
                add_pkt(l, int'($urandom_range(0, 255)));
            end
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
